// File: rtl/iiitb_cg_pkg.sv
// Shared types and widths for the iiitb_cg clock-gating enable controller.
package iiitb_cg_pkg;

    localparam int CG_CNT_W  = 8;
    localparam int CG_STAT_W = 16;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_DRAIN = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    function automatic logic [CG_STAT_W-1:0] cg_sat_inc(input logic [CG_STAT_W-1:0] v);
        return (&v) ? v : v + CG_STAT_W'(1);
    endfunction

endpackage

// File: rtl/iiitb_cg_actdet.sv
// Activity detector: flags a change on d0/d1 against last cycle, or an explicit wake/force.
module iiitb_cg_actdet (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d0_i,
    input  logic d1_i,
    input  logic wake_req_i,
    input  logic force_on_i,
    output logic act_o
);

    logic d0_q;
    logic d1_q;

    // Sample registers clear to 0, so data already high after reset reads as activity.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d0_q <= 1'b0;
            d1_q <= 1'b0;
        end else begin
            d0_q <= d0_i;
            d1_q <= d1_i;
        end
    end

    assign act_o = (d0_i != d0_q) | (d1_i != d1_q) | wake_req_i | force_on_i;

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Clock-gating enable controller driving iiitb_icg.in; drops en after IDLE_CYCLES idle samples.
// Optional gated-cycle statistics counter enabled by defining IIITB_CG_STATS_EN.
module iiitb_cg_ctrl
    import iiitb_cg_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 d0_i,
    input  logic                 d1_i,
    input  logic                 wake_req_i,
    input  logic                 force_on_i,
    output logic                 en_o,
    output logic                 gated_o,
    output logic                 wake_ack_o,
    output logic [CG_CNT_W-1:0]  idle_cnt_o,
    output logic [CG_STAT_W-1:0] gated_cycles_o
);

    localparam logic [CG_CNT_W-1:0] IDLE_LAST = CG_CNT_W'(IDLE_CYCLES - 1);
    localparam logic [3:0]          WAKE_LAST = 4'(WAKE_CYCLES - 1);

    logic                act;
    cg_state_e           state_q, state_d;
    logic [CG_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]          wake_cnt_q, wake_cnt_d;
    logic                en_q, gated_q, wake_ack_q;

    iiitb_cg_actdet u_actdet (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .d0_i       (d0_i),
        .d1_i       (d1_i),
        .wake_req_i (wake_req_i),
        .force_on_i (force_on_i),
        .act_o      (act)
    );

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            CG_RUN: begin
                if (act) begin
                    idle_cnt_d = '0;
                end else begin
                    state_d    = CG_DRAIN;
                    idle_cnt_d = CG_CNT_W'(1);
                end
            end
            CG_DRAIN: begin
                // Activity wins over the final idle sample, so gating never races a toggle.
                if (act) begin
                    state_d    = CG_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = CG_GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CG_CNT_W'(1);
                end
            end
            CG_GATED: begin
                if (act) begin
                    state_d    = CG_WAKE;
                    wake_cnt_d = '0;
                end
            end
            CG_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = CG_RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = CG_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CG_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            en_q       <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            en_q       <= (state_d != CG_GATED);
            gated_q    <= (state_d == CG_GATED);
            wake_ack_q <= (state_q == CG_WAKE) && (state_d == CG_RUN);
        end
    end

    assign en_o       = en_q;
    assign gated_o    = gated_q;
    assign wake_ack_o = wake_ack_q;
    assign idle_cnt_o = idle_cnt_q;

`ifdef IIITB_CG_STATS_EN
    logic [CG_STAT_W-1:0] gated_cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cycles_q <= '0;
        end else if (state_q == CG_GATED) begin
            gated_cycles_q <= cg_sat_inc(gated_cycles_q);
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Directed self-checking bench for iiitb_cg_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_iiitb_cg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d0 = 1'b0;
    logic        d1 = 1'b0;
    logic        wakeReq = 1'b0;
    logic        forceOn = 1'b0;
    logic        en;
    logic        gated;
    logic        wakeAck;
    logic [7:0]  idleCnt;
    logic [15:0] gatedCycles;

    int testsRun = 0;
    int testsFailed = 0;

`ifdef IIITB_CG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    iiitb_cg_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .d0_i           (d0),
        .d1_i           (d1),
        .wake_req_i     (wakeReq),
        .force_on_i     (forceOn),
        .en_o           (en),
        .gated_o        (gated),
        .wake_ack_o     (wakeAck),
        .idle_cnt_o     (idleCnt),
        .gated_cycles_o (gatedCycles)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gcExp(input int n);
        return STATS ? 16'(n) : 16'h0000;
    endfunction

    // Drive one cycle of inputs, then let the edge pass and settle before checking.
    task automatic applyStimulus(input logic r, input logic a, input logic b,
                                 input logic w, input logic f);
        rst     = r;
        d0      = a;
        d1      = b;
        wakeReq = w;
        forceOn = f;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectAll(input string tag, input logic expEn, input logic expGated,
                             input logic expAck, input logic [7:0] expIdle,
                             input logic [15:0] expGc);
        checkOutput({tag, ".en"},       16'(en),      16'(expEn));
        checkOutput({tag, ".gated"},    16'(gated),   16'(expGated));
        checkOutput({tag, ".wakeAck"},  16'(wakeAck), 16'(expAck));
        checkOutput({tag, ".idleCnt"},  16'(idleCnt), 16'(expIdle));
        checkOutput({tag, ".gatedCyc"}, gatedCycles,  expGc);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        expectAll("reset", 1, 0, 0, 8'd0, gcExp(0));

        // Idle countdown into GATED on the 4th idle edge.
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("idle1", 1, 0, 0, 8'd1, gcExp(0));
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("idle2", 1, 0, 0, 8'd2, gcExp(0));
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("idle3", 1, 0, 0, 8'd3, gcExp(0));
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("gate", 0, 1, 0, 8'd0, gcExp(0));
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("gatedHold", 0, 1, 0, 8'd0, gcExp(3));

        // One-cycle d1 toggle wakes; RUN with ack two edges later.
        applyStimulus(0, 0, 1, 0, 0);
        expectAll("wake0", 1, 0, 0, 8'd0, gcExp(4));
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("wake1", 1, 0, 0, 8'd0, gcExp(4));
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("wakeAck", 1, 0, 1, 8'd0, gcExp(4));
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("ackPulse", 1, 0, 0, 8'd1, gcExp(4));

        // Toggle on the very edge that would gate aborts back to RUN.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        expectAll("drain3", 1, 0, 0, 8'd3, gcExp(4));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("abort", 1, 0, 0, 8'd0, gcExp(4));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("abortIdle", 1, 0, 0, 8'd1, gcExp(4));

        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 0, 1);
            checkOutput("force.en", 16'(en), 16'd1);
            checkOutput("force.idleCnt", 16'(idleCnt), 16'd0);
        end

        applyStimulus(0, 1, 0, 0, 0);
        expectAll("rel1", 1, 0, 0, 8'd1, gcExp(4));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("rel2", 1, 0, 0, 8'd2, gcExp(4));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("rel3", 1, 0, 0, 8'd3, gcExp(4));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("relGate", 0, 1, 0, 8'd0, gcExp(4));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("relGated", 0, 1, 0, 8'd0, gcExp(5));

        applyStimulus(1, 1, 0, 0, 0);
        expectAll("rstGated", 1, 0, 0, 8'd0, gcExp(0));

        // d0 held high across reset reads as activity on the first free edge.
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("postRstAct", 1, 0, 0, 8'd0, gcExp(0));
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("postRstIdle1", 1, 0, 0, 8'd1, gcExp(0));
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        expectAll("gate2", 0, 1, 0, 8'd0, gcExp(0));

        // wake_req held high through WAKE must not shorten it.
        applyStimulus(0, 1, 0, 1, 0);
        expectAll("reqWake0", 1, 0, 0, 8'd0, gcExp(1));
        applyStimulus(0, 1, 0, 1, 0);
        expectAll("reqWake1", 1, 0, 0, 8'd0, gcExp(1));
        applyStimulus(0, 1, 0, 1, 0);
        expectAll("reqAck", 1, 0, 1, 8'd0, gcExp(1));
        applyStimulus(0, 1, 0, 1, 0);
        expectAll("reqRun", 1, 0, 0, 8'd0, gcExp(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/iiitb_cg_ctrl.md
# iiitb_cg_ctrl

Clock-gating enable controller that sits directly upstream of `iiitb_icg` and drives its `in` (enable) input. It watches the same `d0`/`d1` data the gated flops capture, plus an explicit wake request. After a programmable number of consecutive idle cycles it drops the enable, and it restores the enable on new activity. It is a small registered FSM clocked by the free-running (ungated) `clk`.

## Interface
- `IDLE_CYCLES`, default 8: consecutive idle samples before gating; legal 2..255.
- `WAKE_CYCLES`, default 2: cycles spent in WAKE before returning to RUN; legal 1..15.
- `clk`, input, 1: free-running clock, the ungated source of the ICG.
- `rst`, input, 1: reset, synchronous and active-high.
- `d0`, input, 1: monitored data bit 0.
- `d1`, input, 1: monitored data bit 1.
- `wake_req`, input, 1: explicit activity request, level-sensitive.
- `force_on`, input, 1: test/override; while high the clock is never gated.
- `en`, output, 1: registered enable to `iiitb_icg.in`.
- `gated`, output, 1: high exactly while in GATED.
- `wake_ack`, output, 1: single-cycle pulse on the WAKE→RUN transition.
- `idle_cnt`, output, 8: current idle counter value.
- `gated_cycles`, output, 16: saturating count of GATED cycles; see Configuration.

## Operation
- Activity detection:
  - `d0_q` and `d1_q` are registered copies of `d0` and `d1`, both reset to 0.
  - `act = (d0 != d0_q) | (d1 != d1_q) | wake_req | force_on`.
- FSM states are RUN, DRAIN, GATED and WAKE. All transitions happen on the `clk` rising edge.
- RUN (`en`=1):
  - `act` → stay in RUN.
  - `!act` → DRAIN, `idle_cnt`=1.
- DRAIN (`en`=1):
  - `act` → RUN, `idle_cnt`=0.
  - `!act` and `idle_cnt`==`IDLE_CYCLES`-1 → GATED, `idle_cnt`=0.
  - Otherwise `idle_cnt`+1.
- GATED (`en`=0, `gated`=1):
  - `act` → WAKE, wake counter=0.
  - Otherwise stay.
- WAKE (`en`=1):
  - Counts `WAKE_CYCLES` cycles, then → RUN with `wake_ack`=1 for that one cycle.
  - `act` during WAKE is ignored; there is no early exit and no re-entry to DRAIN.
- `en`, `gated` and `wake_ack` are registered, decoded from next-state.
- Reset values:
  - `en`=1 (clock running is the safe default).
  - `gated`=0, `wake_ack`=0, `idle_cnt`=0, `gated_cycles`=0.
  - State is RUN.
- Simultaneous events:
  - `rst` overrides everything.
  - `force_on` together with any other input behaves as `act`.
  - A data toggle on the same edge that would enter GATED keeps the FSM in DRAIN→RUN; gating does not occur.

## Timing
- Gate latency: the FSM enters GATED, and `en` falls, at the edge sampling the `IDLE_CYCLES`-th consecutive idle cycle.
- Wake latency:
  - Activity sampled at edge k gives `en`=1 from edge k.
  - RUN with `wake_ack` is reached at edge k+`WAKE_CYCLES`.
- First cycle after reset: a `d0` or `d1` already at 1 counts as a change from 0, i.e. activity.
- Reset during any state: the FSM is back in RUN with `en`=1 at the first edge with `rst` high.

## Configuration
- Macro `IIITB_CG_STATS_EN`.
- Defined:
  - `gated_cycles` increments once per cycle spent in GATED, saturating at 16'hFFFF.
  - It is cleared only by `rst`.
- Undefined: the counter logic is removed and `gated_cycles` is tied to 16'h0000. The port list is unchanged.

## Structure
- Package `iiitb_cg_pkg` holds:
  - the state enum (`CG_RUN`, `CG_DRAIN`, `CG_GATED`, `CG_WAKE`);
  - `CG_CNT_W`=8;
  - `CG_STAT_W`=16.
- Sub-module `iiitb_cg_actdet` contains the `d0`/`d1` sample registers and the `act` equation. The FSM, counters and stats logic stay in the top module.

## Test plan
All cases use `IDLE_CYCLES`=4, `WAKE_CYCLES`=2 and `IIITB_CG_STATS_EN` defined.
- Reset: hold `rst`=1 for 2 cycles with `d0`=`d1`=0 → `en`=1, `gated`=0, `wake_ack`=0, `idle_cnt`=0, `gated_cycles`=0.
- Idle gating: release reset and hold all inputs at 0 → `idle_cnt` reads 1, 2, 3 on successive edges; on the 4th edge `en`=0, `gated`=1, `idle_cnt`=0.
- Wake: in GATED, toggle `d1` for one cycle → `en`=1 at the sampling edge; 2 edges later RUN with `wake_ack`=1 for exactly 1 cycle; `gated_cycles` equals the number of GATED cycles.
- Drain abort: in DRAIN with `idle_cnt`=3, toggle `d0` → next edge RUN, `idle_cnt`=0, `en` never drops.
- Force: `force_on`=1 for 20 cycles with static data → `en`=1 throughout; after release, `en`=0 at the 4th edge.
- Reset mid-GATED: assert `rst` for 1 cycle → `en`=1, state RUN, `gated_cycles`=0 at that edge.
